regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port general-purpose register file for the CPU ID stage.
//  - One synchronous write port; NRD combinational read ports.
//  - Hardware init sweep zeroes every register after reset.
//  - Per-register pending-write scoreboard for hazard detection.
//  - Optional write-to-read bypass.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; number of registers NREG = 2**ADDR_W
//  NRD       2   number of read ports
//  ZERO_REG  1   1: register 0 reads as zero, ignores writes and is never marked pending
// PORTS
//  clk          in   1             clock; all state changes on its rising edge
//  rst          in   1             reset; asynchronous, active-low
//  re           in   NRD           per-port read enable
//  raddr        in   NRD*ADDR_W    read addresses; port i at [i*ADDR_W +: ADDR_W]
//  rdata        out  NRD*DATA_W    read data; port i at [i*DATA_W +: DATA_W]
//  rbusy        out  NRD           port i addresses a register with a pending write
//  we           in   1             write enable (writeback stage)
//  waddr        in   ADDR_W        write address
//  wdata        in   DATA_W        write data
//  sb_set       in   1             issue: mark sb_addr as pending
//  sb_addr      in   ADDR_W        register marked by sb_set
//  sb_flush     in   1             clear all pending bits (pipeline flush)
//  ready        out  1             init sweep complete; file accepts traffic
// BEHAVIOUR
//  Reset (rst=0, async): FSM=INIT, sweep counter=0, all pending bits=0, ready=0.
//   While in reset, rdata=0 and rbusy=0.
//  FSM INIT: each cycle, regs[cnt]<=0 and cnt++.
//   - When cnt==NREG-1, go to RUN on the next edge. Sweep takes exactly NREG cycles after rst rises.
//   - In INIT: we, sb_set and sb_flush are ignored; rdata=0; rbusy=0.
//   - Reset asserted mid-sweep restarts the sweep from register 0.
//  FSM RUN: ready=1. No exit except reset.
//  Write (RUN): on we=1, regs[waddr]<=wdata at the edge.
//   - Ignored when ZERO_REG=1 and waddr==0.
//  Read, combinational, zero latency, per port i:
//   - rdata_i=0 if re_i=0, or ready=0, or (ZERO_REG=1 and raddr_i==0).
//   - else bypass hit (see CONFIGURATION) -> wdata.
//   - else regs[raddr_i].
//   - Ports are independent; two ports on the same address return identical data.
//  Scoreboard pend[NREG], updated at the edge in RUN. Priority, highest first:
//   1. sb_flush=1: all bits cleared; a same-cycle sb_set is dropped.
//   2. sb_set=1: pend[sb_addr]<=1. Wins over a same-cycle we to the same address (new producer).
//   3. we=1: pend[waddr]<=0.
//   - sb_set to address 0 is ignored when ZERO_REG=1.
//  rbusy_i = re_i & ready & pend[raddr_i], masked to 0 on a bypass hit.
//  Pending bits do not block reads or writes. Hazard stalling is the consumer's decision.
// CONFIGURATION
//  RF_BYPASS_EN defined:
//   - Bypass hit = re_i & we & ready & (waddr==raddr_i) & !(ZERO_REG & raddr_i==0).
//   - On a hit: rdata_i=wdata and rbusy_i=0 in the same cycle.
//  RF_BYPASS_EN undefined:
//   - No bypass path. A same-cycle read returns the old register value.
//   - rbusy_i reflects pend as stored.
// TESTING
//  1. Release rst, hold re=all 1s -> ready=0 for exactly 2**ADDR_W cycles (32 at defaults), rdata=0 throughout; then ready=1 and every register reads 0.
//  2. RUN: write r5=0xDEADBEEF; next cycle raddr0=5, raddr1=5 -> both ports 0xDEADBEEF. Write r0=0x1234 -> r0 reads 0.
//  3. Same cycle we=1, waddr=7, wdata=0xA5A5A5A5, raddr0=7 (r7 holds 0x11) -> rdata0=0xA5A5A5A5 with RF_BYPASS_EN, 0x00000011 without; both read 0xA5A5A5A5 next cycle.
//  4. sb_set r9 -> rbusy0=1 at raddr0=9. Then sb_set r9 with we r9 in the same cycle -> stays pending. we r9 alone -> rbusy0=0. Then sb_set r3, r4 followed by sb_flush -> rbusy=0 for both.
//  5. Pull rst low at sweep count 10, release -> ready rises a full 32 cycles later; prior contents read 0; pending bits clear.
//  6. NRD=4, ADDR_W=4: four ports on distinct addresses 1..4 after writes 0x10..0x40 -> each port returns its own value; ready after 16 cycles.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a post-reset zeroing sweep and a pending-write scoreboard.
// Optional same-cycle write-to-read bypass: define RF_BYPASS_EN.
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD-1:0]        re,
   input  logic [NRD*ADDR_W-1:0] raddr,
   output logic [NRD*DATA_W-1:0] rdata,
   output logic [NRD-1:0]        rbusy,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  sb_set,
   input  logic [ADDR_W-1:0]     sb_addr,
   input  logic                  sb_flush,
   output logic                  ready
);

   localparam int                NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREG - 1);
   localparam bit                ZR   = (ZERO_REG != 0);

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e              state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic                ready_q;
   logic [DATA_W-1:0]   regs_q [NREG];
   logic [NREG-1:0]     pend_q;
   logic [NREG-1:0]     pend_d;
   logic                wr_en;
   logic                set_en;

   // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_INIT: begin
               cnt_q <= cnt_q + ADDR_W'(1);
               if (cnt_q == LAST) begin
                  state_q <= ST_RUN;
                  ready_q <= 1'b1;
               end
            end
            ST_RUN: ready_q <= 1'b1;
         endcase
      end
   end

   assign ready  = ready_q;
   assign wr_en  = ready_q & we & ~(ZR & (waddr == '0));
   assign set_en = sb_set & ~(ZR & (sb_addr == '0));

   // NOTE: the array has no reset branch; the INIT sweep zeroes it, so it can map onto reset-less storage.
   always_ff @(posedge clk) begin
      if (!ready_q) begin
         regs_q[cnt_q] <= '0;
      end else if (wr_en) begin
         regs_q[waddr] <= wdata;
      end
   end

   // Priority: flush, then issue-set, then writeback-clear (set is applied last so it wins).
   always_comb begin
      pend_d = pend_q; // NOTE: default assignment first keeps this purely combinational (no latch).
      if (ready_q) begin
         if (sb_flush) begin
            pend_d = '0;
         end else begin
            if (we) begin
               pend_d[waddr] = 1'b0;
            end
            if (set_en) begin
               pend_d[sb_addr] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              valid;
      logic              bypass_hit;

      assign ra    = raddr[gi*ADDR_W +: ADDR_W];
      assign valid = re[gi] & ready_q & ~(ZR & (ra == '0));
`ifdef RF_BYPASS_EN
      assign bypass_hit = valid & we & (waddr == ra);
`else
      assign bypass_hit = 1'b0;
`endif
      assign rdata[gi*DATA_W +: DATA_W] = !valid     ? '0    :
                                          bypass_hit ? wdata : regs_q[ra];
      assign rbusy[gi] = valid & pend_q[ra] & ~bypass_hit;
   end

endmodule
